// File: rtl/ds_skid_pipeline.sv
// ds_skid_pipeline: STAGES cascaded skid buffers; ready is a register output, o_cnt counts held words.
// Optional synchronous flush input clr is present when DS_SKID_PIPELINE_CLEAR_EN is defined.
module ds_skid_pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic [WIDTH-1:0]              i_dat,
    input  logic                          i_val,
    output logic                          i_rdy,
    output logic [WIDTH-1:0]              o_dat,
    output logic                          o_val,
    input  logic                          o_rdy,
`ifdef DS_SKID_PIPELINE_CLEAR_EN
    input  logic                          clr,
`endif
    output logic [$clog2(2*STAGES+1)-1:0] o_cnt
);
    localparam int CW = $clog2(2*STAGES+1);

    logic [STAGES-1:0]            main_val_q, main_val_d, skid_val_q, skid_val_d;
    logic [STAGES-1:0][WIDTH-1:0] main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    // Chains join neighbouring stages: entry s is the upstream side of stage s,
    // entry s+1 its downstream side; the ends are the module ports.
    logic [STAGES:0]              val_chain, rdy_chain;
    logic [STAGES:0][WIDTH-1:0]   dat_chain;

    assign val_chain = {main_val_q, i_val};
    assign dat_chain = {main_dat_q, i_dat};
    assign rdy_chain = {o_rdy, ~skid_val_q};

    assign i_rdy = rdy_chain[0];
    assign o_val = val_chain[STAGES];
    assign o_dat = dat_chain[STAGES];
    assign o_cnt = cnt_q;

    always_comb begin
        main_val_d = main_val_q;
        main_dat_d = main_dat_q;
        skid_val_d = skid_val_q;
        skid_dat_d = skid_dat_q;
        cnt_d      = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (!main_val_q[s] || rdy_chain[s+1]) begin
                if (skid_val_q[s]) begin
                    main_val_d[s] = 1'b1;
                    main_dat_d[s] = skid_dat_q[s];
                    skid_val_d[s] = 1'b0;
                end else begin
                    main_val_d[s] = val_chain[s];
                    if (val_chain[s]) begin
                        main_dat_d[s] = dat_chain[s];
                    end
                end
            end else if (val_chain[s] && !skid_val_q[s]) begin
                skid_val_d[s] = 1'b1;
                skid_dat_d[s] = dat_chain[s];
            end
        end
`ifdef DS_SKID_PIPELINE_CLEAR_EN
        if (clr) begin
            main_val_d = '0;
            skid_val_d = '0;
        end
`endif
        for (int unsigned s = 0; s < STAGES; s++) begin
            cnt_d = cnt_d + CW'(main_val_d[s]) + CW'(skid_val_d[s]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_val_q <= '0;
            main_dat_q <= '0;
            skid_val_q <= '0;
            skid_dat_q <= '0;
            cnt_q      <= '0;
        end else begin
            main_val_q <= main_val_d;
            main_dat_q <= main_dat_d;
            skid_val_q <= skid_val_d;
            skid_dat_q <= skid_dat_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ds_skid_pipeline.sv
// Self-checking bench for ds_skid_pipeline: queue-based reference plus directed literal checks.
// Define DS_SKID_PIPELINE_CLEAR_EN to also exercise the flush input.
module tb_ds_skid_pipeline;
    localparam int S  = 2;
    localparam int CW = $clog2(2*S+1);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    i_dat, o_dat;
    logic          i_val, i_rdy, o_val, o_rdy;
    logic [CW-1:0] o_cnt;
    logic [7:0]    b_idat, b_odat;
    logic          b_ival, b_irdy, b_oval, b_ordy;
    logic [1:0]    b_cnt;
`ifdef DS_SKID_PIPELINE_CLEAR_EN
    logic          clr;
`endif

    ds_skid_pipeline #(.WIDTH(8), .STAGES(S)) dut (
        .reset(reset), .clk(clk),
        .i_dat(i_dat), .i_val(i_val), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_rdy(o_rdy),
`ifdef DS_SKID_PIPELINE_CLEAR_EN
        .clr(clr),
`endif
        .o_cnt(o_cnt)
    );

    ds_skid_pipeline #(.WIDTH(8), .STAGES(1)) dut1 (
        .reset(reset), .clk(clk),
        .i_dat(b_idat), .i_val(b_ival), .i_rdy(b_irdy),
        .o_dat(b_odat), .o_val(b_oval), .o_rdy(b_ordy),
`ifdef DS_SKID_PIPELINE_CLEAR_EN
        .clr(1'b0),
`endif
        .o_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: words held = accepted minus delivered; delivery order = acceptance order.
    logic [7:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat   = '0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_oval", o_val, 0);
            chk("rst_odat", o_dat, 0);
            chk("rst_cnt",  o_cnt, 0);
            chk("rst_irdy", i_rdy, 1);
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("cnt", o_cnt, q.size());
            if (prev_stall) begin
                chk("stall_val", o_val, 1);
                chk("stall_dat", o_dat, prev_dat);
            end
`ifdef DS_SKID_PIPELINE_CLEAR_EN
            if (clr) begin
                q.delete();
                prev_stall = 1'b0;
            end else
`endif
            begin
                if (o_val && o_rdy) begin
                    if (q.size() == 0) chk("pop_from_empty", q.size(), 1);
                    else               chk("order", o_dat, q.pop_front());
                end
                if (i_val && i_rdy) q.push_back(i_dat);
                prev_stall = o_val && !o_rdy;
                prev_dat   = o_dat;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int         n_acc, n_pop;
    logic [7:0] popped [8];
    logic       r0;

    initial begin
        reset = 1'b1; i_val = 1'b0; i_dat = '0; o_rdy = 1'b0;
        b_ival = 1'b0; b_idat = '0; b_ordy = 1'b0;
`ifdef DS_SKID_PIPELINE_CLEAR_EN
        clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back stream with o_rdy=1: 2-cycle latency, one word per cycle.
        o_rdy = 1'b1;
        for (int k = 0; k < 19; k++) begin
            i_val = (k < 16);
            i_dat = 8'(k + 1);
            @(negedge clk);
            chk("stream_irdy", i_rdy, 1);
            if (k < 2 || k == 18) chk("stream_oval_idle", o_val, 0);
            else begin
                chk("stream_oval", o_val, 1);
                chk("stream_odat", o_dat, k - 1);
            end
            @(posedge clk); #1;
        end

        // Fill with o_rdy=0: exactly four words fit.
        i_val = 1'b0; o_rdy = 1'b0; n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            i_val = 1'b1;
            i_dat = 8'(8'hA0 + n_acc);
            @(negedge clk);
            if (i_rdy) n_acc++;
            @(posedge clk); #1;
        end
        chk("full_accepted", n_acc, 4);
        @(negedge clk);
        chk("full_cnt",  o_cnt, 4);
        chk("full_irdy", i_rdy, 0);
        chk("full_oval", o_val, 1);
        chk("full_odat", o_dat, 8'hA0);
        @(posedge clk); #1;
        o_rdy = 1'b1; n_pop = 0;
        for (int k = 0; k < 8; k++) begin
            i_dat = 8'(8'hA0 + n_acc);
            @(negedge clk);
            if (k == 0) chk("resume_irdy_low", i_rdy, 0);
            if (k == S) chk("resume_irdy_high", i_rdy, 1);
            if (o_val && n_pop < 8) begin
                popped[n_pop] = o_dat;
                n_pop++;
            end
            if (i_rdy) n_acc++;
            @(posedge clk); #1;
        end
        for (int j = 0; j < 5; j++) chk("drain_seq", popped[j], 8'(8'hA0 + j));
        i_val = 1'b0;
        repeat (6) @(posedge clk); #1;

        // Random traffic; o_rdy toggled between edges must not move i_rdy.
        for (int k = 0; k < 10000; k++) begin
            i_val = 1'($urandom_range(0, 1));
            i_dat = 8'($urandom);
            o_rdy = 1'($urandom_range(0, 1));
            #1 r0 = i_rdy;
            o_rdy = ~o_rdy;
            #1 chk("comb_ordy_irdy", i_rdy, r0);
            o_rdy = ~o_rdy;
            @(posedge clk); #1;
        end

        // Reset between edges with three words held.
        i_val = 1'b0; o_rdy = 1'b1;
        repeat (6) @(posedge clk); #1;
        o_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_val = 1'b1;
            i_dat = 8'(8'h11 * (k + 1));
            @(posedge clk); #1;
        end
        i_val = 1'b0;
        @(negedge clk);
        chk("held3_cnt", o_cnt, 3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_oval", o_val, 0);
        chk("async_rst_cnt",  o_cnt, 0);
        chk("async_rst_irdy", i_rdy, 1);
        chk("async_rst_odat", o_dat, 0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        o_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_oval", o_val, 0);
        end

`ifdef DS_SKID_PIPELINE_CLEAR_EN
        // Flush with a word offered in the same cycle.
        @(posedge clk); #1;
        o_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_val = 1'b1;
            i_dat = 8'(8'h21 + k);
            @(posedge clk); #1;
        end
        clr = 1'b1; i_val = 1'b1; i_dat = 8'h55;
        @(posedge clk); #1;
        clr = 1'b0; i_val = 1'b0; o_rdy = 1'b1;
        @(negedge clk);
        chk("clr_cnt",  o_cnt, 0);
        chk("clr_oval", o_val, 0);
        repeat (6) begin
            @(negedge clk);
            chk("post_clr_oval", o_val, 0);
        end
`endif

        // STAGES=1: two words fill it, latency of one cycle.
        @(posedge clk); #1;
        b_ordy = 1'b0; n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            b_ival = 1'b1;
            b_idat = 8'(8'h30 + n_acc);
            @(negedge clk);
            if (b_irdy) n_acc++;
            @(posedge clk); #1;
        end
        chk("s1_accepted", n_acc, 2);
        @(negedge clk);
        chk("s1_cnt",  b_cnt, 2);
        chk("s1_irdy", b_irdy, 0);
        chk("s1_oval", b_oval, 1);
        chk("s1_odat", b_odat, 8'h30);
        @(posedge clk); #1;
        b_ival = 1'b0; b_ordy = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("s1_drained_cnt", b_cnt, 0);
        b_ival = 1'b1; b_idat = 8'h77;
        @(negedge clk);
        chk("s1_lat_before", b_oval, 0);
        @(posedge clk); #1 b_ival = 1'b0;
        @(negedge clk);
        chk("s1_lat_oval", b_oval, 1);
        chk("s1_lat_odat", b_odat, 8'h77);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
